// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the RISC-V writeback stage.
// Result sources, load funct3 encodings and the stage FSM states.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_CSR  = 2'd3
    } res_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_WAIT_LD = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic wb_state_e accept_state(input res_src_e src);
        return (src == RES_LOAD) ? ST_WAIT_LD : ST_FULL;
    endfunction

endpackage

// File: rtl/rv_wb_ldfmt.sv
// Load data formatter: byte-lane select and sign/zero extension.
// Lanes wrap modulo XLEN/8, so a misaligned access rotates the word.
module rv_wb_ldfmt
    import rv_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  ld_data,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] rot;

    // rotating through a doubled word gives the lane wraparound for free
    assign rot = XLEN'({ld_data, ld_data} >> {off, 3'b000});

    always_comb begin
        data = rot;
        unique case (funct3)
            F3_LB:   data = XLEN'($signed(rot[7:0]));
            F3_LH:   data = XLEN'($signed(rot[15:0]));
            F3_LW:   data = XLEN'($signed(rot[31:0]));
            F3_LBU:  data = XLEN'(rot[7:0]);
            F3_LHU:  data = XLEN'(rot[15:0]);
            F3_LWU:  data = XLEN'(rot[31:0]);
            F3_LD:   data = rot;
            default: data = rot;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// RISC-V writeback stage: one-entry stage register, load wait FSM,
// result mux, register-file write port and retire counter.
module rv_writeback
    import rv_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int CNT_W  = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic [XLEN-1:0]   i_pc_p4,
    input  logic [XLEN-1:0]   i_csr_data,
    input  logic [1:0]        i_res_src,
    input  logic [2:0]        i_funct3,
    input  logic              i_reg_write,
    input  logic [RIDX_W-1:0] i_rd,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_ld_data,
    input  logic              i_ld_valid,
    output logic [XLEN-1:0]   o_data,
    output logic [RIDX_W-1:0] o_rd,
    output logic              o_reg_write,
    output logic              o_fwd_valid,
    output logic              o_retire,
    output logic [CNT_W-1:0]  o_instret
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_pc_p4;
    logic [XLEN-1:0]   r_csr_data;
    res_src_e          r_res_src;
    logic [2:0]        r_funct3;
    logic              r_reg_write;
    logic [RIDX_W-1:0] r_rd;

    logic [XLEN-1:0]   ld_fmt;
    logic [XLEN-1:0]   wb_data;
    logic              complete;
    logic              accept;

    rv_wb_ldfmt #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_ldfmt (
        .ld_data (i_ld_data),
        .off     (r_alu_result[OFF_W-1:0]),
        .funct3  (r_funct3),
        .data    (ld_fmt)
    );

    always_comb begin
        complete = 1'b0;
        o_ready  = 1'b1;
        unique case (state)
            ST_FULL: complete = 1'b1;
            ST_WAIT_LD: begin
                complete = i_ld_valid;
                o_ready  = i_ld_valid;
            end
            default: complete = 1'b0;
        endcase
        // a flushed or resetting cycle completes nothing and drops any accept
        if (i_reset || i_flush) begin
            complete = 1'b0;
            o_ready  = 1'b1;
        end
    end

    assign accept = i_valid && o_ready && !i_flush && !i_reset;

    always_comb begin
        state_nxt = state;
        if (i_flush)
            state_nxt = ST_EMPTY;
        else if (accept)
            state_nxt = accept_state(res_src_e'(i_res_src));
        else if (state != ST_WAIT_LD || complete)
            state_nxt = ST_EMPTY;
    end

    always_comb begin
        wb_data = '0;
        unique case (r_res_src)
            RES_ALU:  wb_data = r_alu_result;
            RES_LOAD: wb_data = ld_fmt;
            RES_PC4:  wb_data = r_pc_p4;
            RES_CSR:  wb_data = r_csr_data;
            default:  wb_data = '0;
        endcase
    end

    assign o_reg_write = complete && r_reg_write && (r_rd != '0);
    assign o_fwd_valid = o_reg_write;
    assign o_data      = o_reg_write ? wb_data : '0;
    assign o_rd        = o_reg_write ? r_rd : '0;
    assign o_retire    = complete;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_EMPTY;
            r_alu_result <= '0;
            r_pc_p4      <= '0;
            r_csr_data   <= '0;
            r_res_src    <= RES_ALU;
            r_funct3     <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            o_instret    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_alu_result <= i_alu_result;
                r_pc_p4      <= i_pc_p4;
                r_csr_data   <= i_csr_data;
                r_res_src    <= res_src_e'(i_res_src);
                r_funct3     <= i_funct3;
                r_reg_write  <= i_reg_write;
                r_rd         <= i_rd;
            end
            if (complete)
                o_instret <= o_instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// Directed testbench for rv_writeback.
// A second instance with a 4-bit counter exercises instret wraparound.
module tb_rv_writeback;
    import rv_wb_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_pc_p4 = '0;
    logic [31:0] i_csr_data = '0;
    logic [1:0]  i_res_src = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_rd = '0;
    logic        i_flush = 1'b0;
    logic [31:0] i_ld_data = '0;
    logic        i_ld_valid = 1'b0;

    logic        o_ready;
    logic [31:0] o_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_fwd_valid;
    logic        o_retire;
    logic [63:0] o_instret;

    logic        w_ready;
    logic [31:0] w_data;
    logic [4:0]  w_rd;
    logic        w_reg_write;
    logic        w_fwd_valid;
    logic        w_retire;
    logic [3:0]  w_instret;

    int n_vec = 0;
    int n_err = 0;
    int exp_instret = 0;

    always #5 i_clk = ~i_clk;

    rv_writeback u_dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_alu_result (i_alu_result),
        .i_pc_p4      (i_pc_p4),
        .i_csr_data   (i_csr_data),
        .i_res_src    (i_res_src),
        .i_funct3     (i_funct3),
        .i_reg_write  (i_reg_write),
        .i_rd         (i_rd),
        .i_flush      (i_flush),
        .i_ld_data    (i_ld_data),
        .i_ld_valid   (i_ld_valid),
        .o_data       (o_data),
        .o_rd         (o_rd),
        .o_reg_write  (o_reg_write),
        .o_fwd_valid  (o_fwd_valid),
        .o_retire     (o_retire),
        .o_instret    (o_instret)
    );

    rv_writeback #(.CNT_W(4)) u_wrap (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (w_ready),
        .i_alu_result (i_alu_result),
        .i_pc_p4      (i_pc_p4),
        .i_csr_data   (i_csr_data),
        .i_res_src    (i_res_src),
        .i_funct3     (i_funct3),
        .i_reg_write  (i_reg_write),
        .i_rd         (i_rd),
        .i_flush      (i_flush),
        .i_ld_data    (i_ld_data),
        .i_ld_valid   (i_ld_valid),
        .o_data       (w_data),
        .o_rd         (w_rd),
        .o_reg_write  (w_reg_write),
        .o_fwd_valid  (w_fwd_valid),
        .o_retire     (w_retire),
        .o_instret    (w_instret)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [2:0] f3,
                         input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] csr);
        i_valid      = 1'b1;
        i_res_src    = src;
        i_funct3     = f3;
        i_reg_write  = we;
        i_rd         = rd;
        i_alu_result = alu;
        i_pc_p4      = pc4;
        i_csr_data   = csr;
    endtask

    task automatic idle();
        i_valid      = 1'b0;
        i_res_src    = '0;
        i_funct3     = '0;
        i_reg_write  = 1'b0;
        i_rd         = '0;
        i_alu_result = '0;
        i_pc_p4      = '0;
        i_csr_data   = '0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive(RES_ALU, F3_LB, 1'b1, 5'd1, 32'h5, 32'h0, 32'h0);
        tick();
        tick();
        #2;
        n_vec++;
        if (o_retire !== 1'b0) begin
            n_err++; $display("FAIL rst_hold_retire got %b want 0", o_retire);
        end
        i_reset = 1'b0;
        idle();
        #2;
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_ready got %b want 1", o_ready);
        end
        n_vec++;
        if ({o_reg_write, o_fwd_valid, o_retire} !== 3'b000) begin
            n_err++; $display("FAIL rst_ctrl got %b want 000",
                              {o_reg_write, o_fwd_valid, o_retire});
        end
        n_vec++;
        if (o_data !== 32'h0 || o_rd !== 5'd0) begin
            n_err++; $display("FAIL rst_data got %h/%0d want 0/0", o_data, o_rd);
        end
        n_vec++;
        if (o_instret !== 64'd0) begin
            n_err++; $display("FAIL rst_instret got %0d want 0", o_instret);
        end
        exp_instret = 0;
        tick();
        #2;
        n_vec++;
        if (o_retire !== 1'b0 || o_instret !== 64'd0) begin
            n_err++; $display("FAIL rst_no_accept got %b/%0d want 0/0",
                              o_retire, o_instret);
        end
    endtask

    task automatic test_alu();
        drive(RES_ALU, F3_LB, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0);
        #2;
        n_vec++;
        if (o_ready !== 1'b1) begin
            n_err++; $display("FAIL alu_ready got %b want 1", o_ready);
        end
        tick();
        idle();
        #2;
        n_vec++;
        if (o_reg_write !== 1'b1 || o_fwd_valid !== 1'b1) begin
            n_err++; $display("FAIL alu_we got %b/%b want 1/1",
                              o_reg_write, o_fwd_valid);
        end
        n_vec++;
        if (o_rd !== 5'd5 || o_data !== 32'h1234) begin
            n_err++; $display("FAIL alu_data got %0d/%h want 5/00001234",
                              o_rd, o_data);
        end
        n_vec++;
        if (o_retire !== 1'b1) begin
            n_err++; $display("FAIL alu_retire got %b want 1", o_retire);
        end
        exp_instret++;
        tick();
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret) || o_retire !== 1'b0) begin
            n_err++; $display("FAIL alu_instret got %0d/%b want %0d/0",
                              o_instret, o_retire, exp_instret);
        end
    endtask

    task automatic test_sources();
        logic [1:0]  src[4]  = '{RES_PC4, RES_CSR, RES_ALU, RES_PC4};
        logic        we[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0]  rd[4]   = '{5'd9, 5'd3, 5'd7, 5'd0};
        logic        ew[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] ed[4]   = '{32'h2004, 32'hCAFE, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(src[i], F3_LW, we[i], rd[i], 32'hAAAA, 32'h2004, 32'hCAFE);
            tick();
            idle();
            #2;
            n_vec++;
            if (o_reg_write !== ew[i] || o_retire !== 1'b1) begin
                n_err++; $display("FAIL src%0d_ctrl got we=%b ret=%b want %b/1",
                                  i, o_reg_write, o_retire, ew[i]);
            end
            n_vec++;
            if (o_data !== ed[i]) begin
                n_err++; $display("FAIL src%0d_data got %h want %h",
                                  i, o_data, ed[i]);
            end
            exp_instret++;
            tick();
        end
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL src_instret got %0d want %0d",
                              o_instret, exp_instret);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3[7]  = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LH};
        logic [31:0] adr[7] = '{32'h1003, 32'h1003, 32'h1002, 32'h2002,
                                32'h1000, 32'h1001, 32'h1003};
        logic [31:0] dat[7] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF,
                                32'h80FFFFFF, 32'h80FFFFFF, 32'h12345678,
                                32'h12345678};
        int          dly[7] = '{3, 3, 1, 2, 1, 1, 2};
        logic [31:0] exd[7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                32'h000080FF, 32'h80FFFFFF, 32'h00000056,
                                32'h00007812};
        for (int i = 0; i < 7; i++) begin
            drive(RES_LOAD, f3[i], 1'b1, 5'(10 + i), adr[i], 32'h0, 32'h0);
            tick();
            idle();
            for (int c = 1; c < dly[i]; c++) begin
                #2;
                n_vec++;
                if (o_ready !== 1'b0 || o_reg_write !== 1'b0 || o_retire !== 1'b0) begin
                    n_err++; $display("FAIL ld%0d_wait%0d got rdy=%b we=%b ret=%b want 0/0/0",
                                      i, c, o_ready, o_reg_write, o_retire);
                end
                tick();
            end
            i_ld_valid = 1'b1;
            i_ld_data  = dat[i];
            #2;
            n_vec++;
            if (o_ready !== 1'b1 || o_reg_write !== 1'b1 || o_rd !== 5'(10 + i)) begin
                n_err++; $display("FAIL ld%0d_done got rdy=%b we=%b rd=%0d want 1/1/%0d",
                                  i, o_ready, o_reg_write, o_rd, 10 + i);
            end
            n_vec++;
            if (o_data !== exd[i]) begin
                n_err++; $display("FAIL ld%0d_data got %h want %h",
                                  i, o_data, exd[i]);
            end
            exp_instret++;
            tick();
            i_ld_valid = 1'b0;
        end
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL ld_instret got %0d want %0d",
                              o_instret, exp_instret);
        end
    endtask

    task automatic test_flush();
        drive(RES_LOAD, F3_LW, 1'b1, 5'd8, 32'h0, 32'h0, 32'h0);
        tick();
        idle();
        tick();
        i_flush    = 1'b1;
        i_ld_valid = 1'b1;
        i_ld_data  = 32'hDEADBEEF;
        #2;
        n_vec++;
        if (o_reg_write !== 1'b0 || o_retire !== 1'b0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL fl_ld got we=%b ret=%b rdy=%b want 0/0/1",
                              o_reg_write, o_retire, o_ready);
        end
        tick();
        i_flush = 1'b0;
        #2;
        n_vec++;
        if (o_reg_write !== 1'b0 || o_retire !== 1'b0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL fl_empty got we=%b ret=%b rdy=%b want 0/0/1",
                              o_reg_write, o_retire, o_ready);
        end
        i_ld_valid = 1'b0;
        tick();
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL fl_ld_instret got %0d want %0d",
                              o_instret, exp_instret);
        end
        drive(RES_ALU, F3_LB, 1'b1, 5'd4, 32'h44, 32'h0, 32'h0);
        tick();
        i_flush = 1'b1;
        drive(RES_ALU, F3_LB, 1'b1, 5'd6, 32'h66, 32'h0, 32'h0);
        #2;
        n_vec++;
        if (o_retire !== 1'b0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL fl_full got ret=%b rdy=%b want 0/1",
                              o_retire, o_ready);
        end
        tick();
        i_flush = 1'b0;
        idle();
        #2;
        n_vec++;
        if (o_retire !== 1'b0 || o_reg_write !== 1'b0) begin
            n_err++; $display("FAIL fl_drop got ret=%b we=%b want 0/0",
                              o_retire, o_reg_write);
        end
        tick();
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL fl_instret got %0d want %0d",
                              o_instret, exp_instret);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 5; i++) begin
            if (i < 5)
                drive(RES_ALU, F3_LB, 1'b1, 5'(i + 1), 32'(32'h100 + i),
                      32'h0, 32'h0);
            else
                idle();
            #2;
            if (i > 0) begin
                n_vec++;
                if (o_reg_write !== 1'b1 || o_data !== 32'(32'h100 + i - 1)) begin
                    n_err++; $display("FAIL b2b%0d got we=%b data=%h want 1/%h",
                                      i, o_reg_write, o_data, 32'h100 + i - 1);
                end
                n_vec++;
                if (o_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b%0d_ready got %b want 1", i, o_ready);
                end
                exp_instret++;
            end
            tick();
        end
        drive(RES_LOAD, F3_LBU, 1'b1, 5'd12, 32'h3001, 32'h0, 32'h0);
        tick();
        drive(RES_ALU, F3_LB, 1'b1, 5'd2, 32'h77, 32'h0, 32'h0);
        i_ld_valid = 1'b1;
        i_ld_data  = 32'h0000AB00;
        #2;
        n_vec++;
        if (o_data !== 32'hAB || o_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ld got data=%h rdy=%b want 000000ab/1",
                              o_data, o_ready);
        end
        exp_instret++;
        tick();
        i_ld_valid = 1'b0;
        idle();
        #2;
        n_vec++;
        if (o_reg_write !== 1'b1 || o_data !== 32'h77 || o_rd !== 5'd2) begin
            n_err++; $display("FAIL b2b_after_ld got we=%b data=%h rd=%0d want 1/77/2",
                              o_reg_write, o_data, o_rd);
        end
        exp_instret++;
        tick();
        #2;
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL b2b_instret got %0d want %0d",
                              o_instret, exp_instret);
        end
    endtask

    task automatic test_reset_wait_ld();
        drive(RES_LOAD, F3_LW, 1'b1, 5'd9, 32'h0, 32'h0, 32'h0);
        tick();
        idle();
        i_reset = 1'b1;
        tick();
        i_reset    = 1'b0;
        i_ld_valid = 1'b1;
        i_ld_data  = 32'h11112222;
        exp_instret = 0;
        #2;
        n_vec++;
        if (o_reg_write !== 1'b0 || o_retire !== 1'b0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL rstld got we=%b ret=%b rdy=%b want 0/0/1",
                              o_reg_write, o_retire, o_ready);
        end
        n_vec++;
        if (o_instret !== 64'd0) begin
            n_err++; $display("FAIL rstld_instret got %0d want 0", o_instret);
        end
        tick();
        i_ld_valid = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            drive(RES_ALU, F3_LB, 1'b1, 5'd1, 32'(i), 32'h0, 32'h0);
            tick();
        end
        idle();
        tick();
        exp_instret += 17;
        #2;
        n_vec++;
        if (w_instret !== 4'd1) begin
            n_err++; $display("FAIL wrap_cnt4 got %0d want 1", w_instret);
        end
        n_vec++;
        if (o_instret !== 64'(exp_instret)) begin
            n_err++; $display("FAIL wrap_cnt64 got %0d want %0d",
                              o_instret, exp_instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sources();
        test_loads();
        test_flush();
        test_back_to_back();
        test_reset_wait_ld();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_writeback.md
RV_WRITEBACK -- requirements
Module: rv_writeback

Interface
REQ-001 Parameter XLEN, default 32, register/data width; the only legal values are 32 and 64.
REQ-002 Parameter RIDX_W, default 5, register index width.
REQ-003 Parameter CNT_W, default 64, retire-counter width.
REQ-004 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_valid / o_ready  in / out  1 / 1  upstream handshake; an instruction is accepted when both are 1.
REQ-007 i_alu_result  in  XLEN  ALU result, or effective address for loads.
REQ-008 i_pc_p4  in  XLEN  PC+4 of the instruction.
REQ-009 i_csr_data  in  XLEN  CSR read value.
REQ-010 i_res_src  in  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 CSR.
REQ-011 i_funct3  in  3  load format: LB/LH/LW/LBU/LHU, plus LD/LWU when XLEN=64.
REQ-012 i_reg_write, i_rd  in  1 / RIDX_W  write enable and destination register.
REQ-013 i_flush  in  1  kills the held instruction.
REQ-014 i_ld_data / i_ld_valid  in  XLEN / 1  load return data and its qualifier.
REQ-015 o_data, o_rd, o_reg_write  out  XLEN / RIDX_W / 1  register-file write port.
REQ-016 o_fwd_valid  out  1  o_data/o_rd are valid for forwarding this cycle.
REQ-017 o_retire  out  1  one-cycle pulse per completed instruction.
REQ-018 o_instret  out  CNT_W  retired-instruction count.

Function
REQ-019 States: EMPTY, FULL, WAIT_LD. o_ready=1 in EMPTY, in FULL, and in WAIT_LD when i_ld_valid=1.
REQ-020 Accept in EMPTY: capture inputs into the stage register. Next state is WAIT_LD if res_src=LOAD, else FULL.
REQ-021 FULL completes in its first cycle: o_retire=1 and o_reg_write=r_reg_write && (r_rd!=0). Next state is FULL if a new instruction is accepted that cycle, else EMPTY.
REQ-022 WAIT_LD with i_ld_valid=0: o_ready=0, no write, no retire, stay in WAIT_LD.
REQ-023 WAIT_LD with i_ld_valid=1: complete in the same cycle using the formatted i_ld_data (zero extra latency), then proceed as in FULL.
REQ-024 Latency: an accepted non-load writes one cycle after acceptance; a load writes in the first cycle at or after acceptance+1 in which i_ld_valid=1.
REQ-025 Load format uses byte offset r_alu_result[1:0] (or [2:0] for XLEN=64). Byte and half loads sign- or zero-extend per funct3. Misaligned offsets are not checked; the low bits select the lane, wrapping modulo XLEN/8.
REQ-026 Source mux: ALU uses r_alu_result, PC4 uses r_pc_p4, CSR uses r_csr_data.
REQ-027 o_data is driven only when writing; otherwise it is 0.
REQ-028 o_fwd_valid equals o_reg_write.
REQ-029 i_flush=1 forces next state EMPTY and suppresses any completion that cycle: o_reg_write=0, o_retire=0. An accept in the same cycle is dropped; o_ready reads 1.
REQ-030 While the FSM is in WAIT_LD, an i_ld_valid that coincides with i_flush is discarded.
REQ-031 o_instret increments by 1 on each o_retire and wraps modulo 2^CNT_W.
REQ-032 i_ld_valid in EMPTY or FULL is ignored.

Reset
REQ-033 i_reset=1 has priority over all other inputs.
REQ-034 On reset: state is EMPTY, o_instret=0, all outputs 0 except o_ready=1, and stage-register data fields are cleared.
REQ-035 Reset asserted in WAIT_LD abandons the load. An i_ld_valid arriving after reset is ignored per REQ-032.

Structure
REQ-036 Package rv_wb_pkg holds the res_src enum (RES_ALU, RES_LOAD, RES_PC4, RES_CSR), the funct3 load constants and the state enum.
REQ-037 Sub-module rv_wb_ldfmt, combinational and parametrised by XLEN, performs lane select and extension.
REQ-038 The rest of the RTL, between 120 and 400 lines, holds the FSM, stage register, output mux and counter.

Verification
REQ-039 ALU op: rd=5, alu=0x1234 -> next cycle o_reg_write=1, o_rd=5, o_data=0x1234, o_retire=1, o_instret=1.
REQ-040 LB: alu=0x1003, ld_data=0x80FFFFFF, ld_valid 3 cycles late -> o_ready=0 for 2 cycles, then o_data=0xFFFFFF80. LBU with the same data -> 0x00000080.
REQ-041 Write to rd=0 (res_src=PC4) -> o_reg_write=0 and o_retire=1.
REQ-042 i_flush in WAIT_LD coincident with i_ld_valid -> no write, state EMPTY, o_instret unchanged.
REQ-043 Back-to-back ALU ops at i_valid=1 every cycle -> one write per cycle, o_ready stays 1.
REQ-044 Wrap: CNT_W=4, 17 retires -> o_instret=1.
